fifo_mem_loader: RTL
====================

FIFO_MEM_LOADER -- requirements
Module: fifo_mem_loader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_WIDTH, 32, width of a FIFO word and a memory word.
- MEM_ADDR_WIDTH, 10, width of a target memory word address.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- loader_clk_i  input  1  single clock; all state updates on its rising edge.
- loader_rst_i  input  1  reset; synchronous, active-high.
- loader_start_i  input  1  one-cycle request to begin a transfer.
- loader_base_addr_i  input  MEM_ADDR_WIDTH  first memory word address; sampled on an accepted start.
- loader_length_i  input  MEM_ADDR_WIDTH+1  number of words to transfer; sampled on an accepted start.
- fifo_emptyflag_i  input  1  upstream FIFO empty flag.
- fifo_readdata_i  input  DATA_WIDTH  upstream FIFO head word; valid whenever the empty flag is low.
- fifo_readflag_o  output  1  pop strobe to the FIFO.
- mem_addr_o  output  MEM_ADDR_WIDTH  memory write address.
- mem_writedata_o  output  DATA_WIDTH  memory write data.
- mem_writeen_o  output  1  memory write request; held until acknowledged.
- mem_ack_i  input  1  memory write accepted; sampled only while mem_writeen_o is high.
- loader_busy_o  output  1  transfer in progress.
- loader_done_o  output  1  one-cycle completion pulse.
- loader_count_o  output  MEM_ADDR_WIDTH+1  words written in the current or last transfer.

Function
REQ-003 The FSM SHALL have the states IDLE, CHECK, POP, WRITE and DONE.
REQ-004 IDLE: loader_start_i=1 with loader_length_i!=0 SHALL latch base and length, clear the count and go to CHECK; loader_start_i=1 with loader_length_i==0 SHALL go directly to DONE.
REQ-005 loader_start_i outside IDLE SHALL be ignored.
REQ-006 CHECK: the FSM SHALL stay while fifo_emptyflag_i=1 and go to POP when it is 0.
REQ-007 POP: fifo_readflag_o SHALL be 1 for exactly this one cycle; fifo_readdata_i SHALL be captured into the data register in the same cycle; next state SHALL be WRITE.
REQ-008 fifo_readflag_o SHALL never be asserted while fifo_emptyflag_i=1, and never in two consecutive cycles. Reason: the FIFO advances both pointers on a simultaneous read and write, and its empty flag updates one cycle after a pop.
REQ-009 WRITE: mem_writeen_o SHALL be 1. mem_addr_o SHALL equal (base + count) modulo 2^MEM_ADDR_WIDTH, and mem_writedata_o SHALL equal the captured word. Both SHALL be held stable until mem_ack_i=1.
REQ-010 mem_ack_i=1 in WRITE SHALL increment the count. If the incremented count equals the length the next state SHALL be DONE, otherwise CHECK. An ack in the first WRITE cycle is legal.
REQ-011 DONE: loader_done_o SHALL be 1 for one cycle; next state SHALL be IDLE.
REQ-012 loader_busy_o SHALL be 1 in CHECK, POP and WRITE, and 0 in IDLE and DONE.
REQ-013 Address arithmetic SHALL wrap silently with no error flag. The count SHALL saturate at the length, and loader_count_o SHALL keep its value until the next accepted start.
REQ-014 Throughput SHALL be a minimum of 3 cycles per word (CHECK, POP, WRITE with immediate ack).
REQ-015 mem_ack_i outside WRITE SHALL be ignored.

Reset
REQ-016 loader_rst_i=1 at a rising edge SHALL force IDLE from any state, including mid-WRITE (the pending write is abandoned).
REQ-017 Reset values: fifo_readflag_o=0, mem_writeen_o=0, mem_addr_o=0, mem_writedata_o=0, loader_busy_o=0, loader_done_o=0, loader_count_o=0; the base, length and data registers SHALL also be 0.
REQ-018 Reset SHALL take priority over loader_start_i and mem_ack_i in the same cycle.

Structure
REQ-019 A shared package fifo_loader_pkg SHALL hold the FSM state encoding and the default DATA_WIDTH and MEM_ADDR_WIDTH constants.
REQ-020 The block SHALL be a single flat module: one registered FSM plus address, count and data registers, with no sub-module. The upstream FIFO is connected externally.
REQ-021 All outputs SHALL be driven from registers or decoded from the state register only, with no combinational path from input to output.

Verification
REQ-022 Basic transfer: FIFO preloaded with 0xA0..0xA3, base=0x010, length=4, immediate ack -> writes 0xA0..0xA3 to 0x010..0x013; done pulse at cycle 13 after start; count=4.
REQ-023 Zero length: start with length=0 -> done pulse on the next cycle; no readflag and no writeen ever asserted.
REQ-024 Empty stall: FIFO empty for 20 cycles after start, then 1 word pushed (length=1) -> readflag stays 0 throughout the stall, then exactly one pop and one write.
REQ-025 Ack backpressure: ack delayed by 5 cycles on word 2 -> addr and data held stable for those 5 cycles; no extra pop occurs.
REQ-026 Wrap-around: MEM_ADDR_WIDTH=10, base=0x3FE, length=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001 in that order.
REQ-027 Reset mid-transfer: reset asserted in the WRITE state of word 2 of 4 -> all outputs at reset values the next cycle; a second start with length=2 completes normally.

Source files
------------

// File: rtl/fifo_loader_pkg.sv
// fifo_loader_pkg
//   Shared definitions for the FIFO-to-memory loader: the default word and
//   address widths and the FSM state encoding.
package fifo_loader_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_MEM_ADDR_WIDTH = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_POP   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } loader_state_e;

endpackage

// File: rtl/fifo_mem_loader.sv
// fifo_mem_loader
//   Drains a programmed number of words from an upstream FIFO and writes
//   them to consecutive memory word addresses starting at a base address.
//   One word moves per CHECK -> POP -> WRITE round trip. The pop strobe is
//   therefore never issued back to back, and it is only issued after the
//   empty flag has been seen low.
//
// Ports
//   loader_clk_i        single clock, rising edge
//   loader_rst_i        synchronous active-high reset
//   loader_start_i      one-cycle start request, honoured only when idle
//   loader_base_addr_i  first memory word address (sampled on start)
//   loader_length_i     number of words to move (sampled on start)
//   fifo_emptyflag_i    upstream FIFO empty flag
//   fifo_readdata_i     upstream FIFO head word
//   fifo_readflag_o     pop strobe to the FIFO
//   mem_addr_o          memory write address
//   mem_writedata_o     memory write data
//   mem_writeen_o       memory write request, held until mem_ack_i
//   mem_ack_i           memory write accepted
//   loader_busy_o       transfer in progress
//   loader_done_o       one-cycle completion pulse
//   loader_count_o      words written in the current or last transfer
module fifo_mem_loader
  import fifo_loader_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH
) (
  input  logic                      loader_clk_i,
  input  logic                      loader_rst_i,
  input  logic                      loader_start_i,
  input  logic [MEM_ADDR_WIDTH-1:0] loader_base_addr_i,
  input  logic [MEM_ADDR_WIDTH:0]   loader_length_i,
  input  logic                      fifo_emptyflag_i,
  input  logic [DATA_WIDTH-1:0]     fifo_readdata_i,
  output logic                      fifo_readflag_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_writedata_o,
  output logic                      mem_writeen_o,
  input  logic                      mem_ack_i,
  output logic                      loader_busy_o,
  output logic                      loader_done_o,
  output logic [MEM_ADDR_WIDTH:0]   loader_count_o
);

  localparam int CW = MEM_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  loader_state_e             state_r;
  loader_state_e             next_state_s;
  logic [MEM_ADDR_WIDTH-1:0] base_r;
  logic [MEM_ADDR_WIDTH-1:0] addr_r;
  logic [CW-1:0]             len_r;
  logic [CW-1:0]             count_r;
  logic [CW-1:0]             count_plus_s;
  logic [DATA_WIDTH-1:0]     data_r;

  assign count_plus_s = count_r + CNT_ONE;

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (loader_start_i) begin
          if (loader_length_i != CNT_ZERO) begin
            next_state_s = ST_CHECK;
          end else begin
            next_state_s = ST_DONE;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (!fifo_emptyflag_i) begin
          next_state_s = ST_POP;
        end else begin
          next_state_s = ST_CHECK;
        end
      end
      ST_POP: begin
        next_state_s = ST_WRITE;
      end
      ST_WRITE: begin
        if (mem_ack_i) begin
          if (count_plus_s == len_r) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_CHECK;
          end
        end else begin
          next_state_s = ST_WRITE;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, transfer parameters, address, count and captured data.
  always_ff @(posedge loader_clk_i) begin
    if (loader_rst_i) begin
      state_r <= ST_IDLE;
      base_r  <= {MEM_ADDR_WIDTH{1'b0}};
      addr_r  <= {MEM_ADDR_WIDTH{1'b0}};
      len_r   <= CNT_ZERO;
      count_r <= CNT_ZERO;
      data_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r <= next_state_s;
      case (state_r)
        ST_IDLE: begin
          // A zero-length start goes straight to DONE and leaves the
          // previous transfer's registers untouched.
          if (loader_start_i && (loader_length_i != CNT_ZERO)) begin
            base_r  <= loader_base_addr_i;
            addr_r  <= loader_base_addr_i;
            len_r   <= loader_length_i;
            count_r <= CNT_ZERO;
          end
        end
        ST_POP: begin
          data_r <= fifo_readdata_i;
        end
        ST_WRITE: begin
          // The address is kept as base + count in its own register so the
          // output is a flop; the truncating add gives the silent wrap.
          if (mem_ack_i && (count_r != len_r)) begin
            count_r <= count_plus_s;
            addr_r  <= base_r + count_plus_s[MEM_ADDR_WIDTH-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign fifo_readflag_o = (state_r == ST_POP);
  assign mem_writeen_o   = (state_r == ST_WRITE);
  assign loader_done_o   = (state_r == ST_DONE);
  assign loader_busy_o   = (state_r == ST_CHECK) || (state_r == ST_POP) ||
                           (state_r == ST_WRITE);
  assign mem_addr_o      = addr_r;
  assign mem_writedata_o = data_r;
  assign loader_count_o  = count_r;

endmodule
